// File: rtl/circle_arc_draw.sv
// Midpoint circle rasteriser: emits one candidate pixel per cycle over eight octants,
// gated by an octant mask and clipped to the visible screen.
module circle_arc_draw #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned R_W      = 8,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [X_W-1:0] centre_x,
    input  logic [Y_W-1:0] centre_y,
    input  logic [R_W-1:0] radius,
    input  logic [2:0]     colour,
    input  logic [7:0]     octant_mask,
    output logic           done,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     vga_colour,
    output logic           vga_plot
);
    localparam int unsigned XR_W = (X_W > R_W) ? X_W : R_W;
    localparam int unsigned CW   = ((XR_W > Y_W) ? XR_W : Y_W) + 2;
    localparam int unsigned CRW  = R_W + 2;

    typedef enum logic [1:0] {StIdle, StInit, StPlot, StDone} state_e;

    state_e                state_q, state_d;
    logic [X_W-1:0]        cx_q, cx_d;
    logic [Y_W-1:0]        cy_q, cy_d;
    logic [R_W-1:0]        r_q, r_d;
    logic [2:0]            colour_q, colour_d;
    logic [7:0]            mask_q, mask_d;
    logic signed [CW-1:0]  ox_q, ox_d, oy_q, oy_d;
    logic signed [CRW-1:0] crit_q, crit_d;
    logic [2:0]            k_q, k_d;
    logic                  done_q, done_d, plot_q, plot_d;
    logic [X_W-1:0]        vga_x_q, vga_x_d;
    logic [Y_W-1:0]        vga_y_q, vga_y_d;
    logic [2:0]            vga_colour_q, vga_colour_d;

    logic signed [CW-1:0]  cx_w, cy_w, px, py, oy_n, ox_dec, ox_new;
    logic signed [CRW-1:0] crit_inc;
    logic                  crit_le0, last_iter, on_screen;

    // Bresenham step taken at the end of each eight-cycle iteration.
    always_comb begin
        crit_le0  = crit_q[CRW-1] || (crit_q == '0);
        oy_n      = oy_q + CW'(1);
        ox_dec    = ox_q - CW'(1);
        ox_new    = crit_le0 ? ox_q : ox_dec;
        crit_inc  = crit_le0 ? CRW'((oy_n <<< 1) + CW'(1))
                             : CRW'(((oy_n - ox_dec) <<< 1) + CW'(1));
        last_iter = oy_n > ox_new;
    end

    always_comb begin
        cx_w = CW'(cx_q);
        cy_w = CW'(cy_q);
        px   = cx_w;
        py   = cy_w;
        unique case (k_q)
            3'd0: begin px = cx_w + ox_q; py = cy_w + oy_q; end
            3'd1: begin px = cx_w + oy_q; py = cy_w + ox_q; end
            3'd2: begin px = cx_w - oy_q; py = cy_w + ox_q; end
            3'd3: begin px = cx_w - ox_q; py = cy_w + oy_q; end
            3'd4: begin px = cx_w - ox_q; py = cy_w - oy_q; end
            3'd5: begin px = cx_w - oy_q; py = cy_w - ox_q; end
            3'd6: begin px = cx_w + oy_q; py = cy_w - ox_q; end
            3'd7: begin px = cx_w + ox_q; py = cy_w - oy_q; end
        endcase
        on_screen = !px[CW-1] && (px < CW'(SCREEN_W)) && !py[CW-1] && (py < CW'(SCREEN_H));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StInit;
            StInit:  state_d = StPlot;
            StPlot:  if (k_q == 3'd7 && last_iter) state_d = StDone;
            StDone:  if (!start && done_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cx_d     = cx_q;
        cy_d     = cy_q;
        r_d      = r_q;
        colour_d = colour_q;
        mask_d   = mask_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        crit_d   = crit_q;
        k_d      = k_q;
        unique case (state_q)
            StIdle: if (start) begin
                cx_d     = centre_x;
                cy_d     = centre_y;
                r_d      = radius;
                colour_d = colour;
                mask_d   = octant_mask;
            end
            StInit: begin
                ox_d   = CW'(r_q);
                oy_d   = '0;
                crit_d = CRW'(1) - CRW'(r_q);
                k_d    = 3'd0;
            end
            StPlot: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    oy_d   = oy_n;
                    ox_d   = ox_new;
                    crit_d = crit_q + crit_inc;
                end
            end
            default: ;
        endcase
    end

    // Outputs are registered, so they trail the state by one cycle.
    always_comb begin
        plot_d       = 1'b0;
        done_d       = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = colour_q;
        unique case (state_q)
            StPlot: begin
                plot_d  = mask_q[k_q] && on_screen;
                vga_x_d = px[X_W-1:0];
                vga_y_d = py[Y_W-1:0];
            end
            StDone:  done_d = !done_q || start;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cx_q         <= '0;
            cy_q         <= '0;
            r_q          <= '0;
            colour_q     <= '0;
            mask_q       <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            crit_q       <= '0;
            k_q          <= '0;
            done_q       <= 1'b0;
            plot_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            r_q          <= r_d;
            colour_q     <= colour_d;
            mask_q       <= mask_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            crit_q       <= crit_d;
            k_q          <= k_d;
            done_q       <= done_d;
            plot_q       <= plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
        end
    end

    assign done       = done_q;
    assign vga_plot   = plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;

endmodule

// File: tb/tb_circle_arc_draw.sv
// Bench for circle_arc_draw: integer reference model fills a pixel queue, a negedge monitor
// pops and compares every plotted pixel; the driver checks done timing and reset behaviour.
module tb_circle_arc_draw;
    localparam int SW = 160;
    localparam int SH = 120;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [2:0] colour;
    logic [7:0] octant_mask;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    pix_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    circle_arc_draw dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .radius     (radius),
        .colour     (colour),
        .octant_mask(octant_mask),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Midpoint circle in plain integers; returns the number of candidate-pixel cycles.
    task automatic model(input int cx, input int cy, input int r, input int col,
                         input logic [7:0] mask, output int cycles);
        int   ox, oy, crit, dx, dy, x, y;
        pix_t p;
        ox = r;
        oy = 0;
        crit = 1 - r;
        cycles = 0;
        do begin
            for (int k = 0; k < 8; k++) begin
                case (k)
                    0: begin dx =  ox; dy =  oy; end
                    1: begin dx =  oy; dy =  ox; end
                    2: begin dx = -oy; dy =  ox; end
                    3: begin dx = -ox; dy =  oy; end
                    4: begin dx = -ox; dy = -oy; end
                    5: begin dx = -oy; dy = -ox; end
                    6: begin dx =  oy; dy = -ox; end
                    default: begin dx = ox; dy = -oy; end
                endcase
                x = cx + dx;
                y = cy + dy;
                if (mask[k] && x >= 0 && x < SW && y >= 0 && y < SH) begin
                    p.x = x[7:0];
                    p.y = y[6:0];
                    p.c = col[2:0];
                    exp_q.push_back(p);
                end
                cycles++;
            end
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endtask

    always @(negedge clk) begin
        if (rst_n && vga_plot) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_plot: got (%0d,%0d) expected no plot", vga_x, vga_y);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                check("pix_x", int'(vga_x), int'(e.x));
                check("pix_y", int'(vga_y), int'(e.y));
                check("pix_colour", int'(vga_colour), int'(e.c));
            end
        end
    end

    // Called just after a rising edge with the DUT idle.
    task automatic draw(input int cx, input int cy, input int r, input int col,
                        input logic [7:0] mask, input int hold);
        int cycles, n;
        model(cx, cy, r, col, mask, cycles);
        centre_x    = 8'(cx);
        centre_y    = 7'(cy);
        radius      = 8'(r);
        colour      = 3'(col);
        octant_mask = mask;
        start       = 1'b1;
        @(posedge clk);
        #1;
        n = 1;
        centre_x    = 8'($urandom);
        centre_y    = 7'($urandom);
        radius      = 8'($urandom);
        colour      = 3'($urandom);
        octant_mask = 8'($urandom);
        while (!done && n < cycles + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_latency", n, cycles + 3);
        check("drained", exp_q.size(), 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("done_hold", int'(done), 1);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("done_clear", int'(done), 0);
        exp_q.delete();
    endtask

    initial begin
        int cycles;
        rst_n       = 1'b0;
        start       = 1'b0;
        centre_x    = '0;
        centre_y    = '0;
        radius      = '0;
        colour      = '0;
        octant_mask = '0;
        #12;
        check("rst_done", int'(done), 0);
        check("rst_plot", int'(vga_plot), 0);
        check("rst_x", int'(vga_x), 0);
        check("rst_y", int'(vga_y), 0);
        check("rst_colour", int'(vga_colour), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        draw(80, 60, 0, 3, 8'hFF, 0);
        draw(80, 60, 3, 5, 8'hFF, 0);
        draw(0, 0, 10, 7, 8'hFF, 1);
        draw(80, 60, 20, 2, 8'h03, 0);
        draw(80, 60, 20, 2, 8'hFF, 0);
        draw(150, 110, 15, 6, 8'hFF, 5);
        draw(80, 60, 5, 1, 8'hA5, 2);
        for (int i = 0; i < 10; i++) begin
            draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 80)), int'($urandom_range(0, 7)),
                 8'($urandom), int'($urandom_range(0, 3)));
        end

        // Abort during the fifth iteration.
        model(80, 60, 40, 4, 8'hFF, cycles);
        centre_x    = 8'd80;
        centre_y    = 7'd60;
        radius      = 8'd40;
        colour      = 3'd4;
        octant_mask = 8'hFF;
        start       = 1'b1;
        repeat (37) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_done", int'(done), 0);
        check("abort_plot", int'(vga_plot), 0);
        check("abort_x", int'(vga_x), 0);
        check("abort_y", int'(vga_y), 0);
        check("abort_colour", int'(vga_colour), 0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_idle_done", int'(done), 0);
        draw(40, 30, 12, 3, 8'hFF, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
